// File: rtl/cpu6502_pkg.sv
// Shared cpu6502 definitions: RW bus encoding and the external bus FSM state type.
package cpu6502_pkg;

    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;

    typedef enum logic {
        ACTIVE,
        STALLED
    } bus_state_t;

endpackage

// File: rtl/cpu6502_address_bus_register.sv
// 8-bit load-enable register with asynchronous active-high reset; used for ABL and ABH.
module cpu6502_address_bus_register (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_load,
    input  logic [7:0] i_d,
    output logic [7:0] o_q
);

    logic [7:0] q_q;
    logic [7:0] q_d;

    always_comb begin
        q_d = q_q;
        if (i_load) begin
            q_d = i_d;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            q_q <= 8'h00;
        end else begin
            q_q <= q_d;
        end
    end

    assign o_q = q_q;

endmodule

// File: rtl/cpu6502_bus_interface.sv
// 6502 external bus interface: address/data/RW registers, read data latch and RDY stall FSM.
// Optional completed-cycle counter enabled by defining CPU6502_BUS_CYCLE_COUNT_EN.
module cpu6502_bus_interface
    import cpu6502_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_adl_abl,
    input  logic        i_adh_abh,
    input  logic [7:0]  i_adl,
    input  logic [7:0]  i_adh,
    input  logic        i_db_dor,
    input  logic [7:0]  i_db,
    input  logic        i_rw,
    input  logic        i_rdy,
    input  logic [7:0]  i_data,
    output logic [15:0] o_address,
    output logic        o_rw,
    output logic [7:0]  o_data,
    output logic [7:0]  o_dl,
    output logic        o_stall,
    output logic        o_stalled
`ifdef CPU6502_BUS_CYCLE_COUNT_EN
    ,
    output logic [15:0] o_cycle_count
`endif
);

    bus_state_t state_q, state_d;
    logic       rw_q, rw_d;
    logic [7:0] dor_q, dor_d;
    logic [7:0] dl_q, dl_d;
    logic [7:0] abl, abh;
    logic       complete;

    // Only reads can be stretched; a write always completes.
    assign o_stall  = (rw_q == RW_READ) & ~i_rdy;
    assign complete = ~o_stall;

    cpu6502_address_bus_register u_abl (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_load  (complete & i_adl_abl),
        .i_d     (i_adl),
        .o_q     (abl)
    );

    cpu6502_address_bus_register u_abh (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_load  (complete & i_adh_abh),
        .i_d     (i_adh),
        .o_q     (abh)
    );

    always_comb begin
        state_d = state_q;
        rw_d    = rw_q;
        dor_d   = dor_q;
        dl_d    = dl_q;
        if (complete) begin
            rw_d = i_rw;
            if (i_db_dor) begin
                dor_d = i_db;
            end
            if (rw_q == RW_READ) begin
                dl_d = i_data;
            end
        end
        unique case (state_q)
            ACTIVE:  if (o_stall) state_d = STALLED;
            STALLED: if (i_rdy)   state_d = ACTIVE;
            default: state_d = ACTIVE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q <= ACTIVE;
            rw_q    <= RW_READ;
            dor_q   <= 8'h00;
            dl_q    <= 8'h00;
        end else begin
            state_q <= state_d;
            rw_q    <= rw_d;
            dor_q   <= dor_d;
            dl_q    <= dl_d;
        end
    end

`ifdef CPU6502_BUS_CYCLE_COUNT_EN
    logic [15:0] count_q;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            count_q <= 16'h0000;
        end else if (complete) begin
            count_q <= count_q + 16'h0001;
        end
    end

    assign o_cycle_count = count_q;
`endif

    assign o_address = {abh, abl};
    assign o_rw      = rw_q;
    assign o_data    = (rw_q == RW_WRITE) ? dor_q : 8'h00;
    assign o_dl      = dl_q;
    assign o_stalled = (state_q == STALLED);

endmodule

// File: tb/tb_cpu6502_bus_interface.sv
// Directed self-checking bench for cpu6502_bus_interface (counter checks need
// CPU6502_BUS_CYCLE_COUNT_EN).
module tb_cpu6502_bus_interface;

    logic        i_clk = 1'b0;
    logic        i_reset;
    logic        i_adl_abl, i_adh_abh, i_db_dor, i_rw, i_rdy;
    logic [7:0]  i_adl, i_adh, i_db, i_data;
    logic [15:0] o_address;
    logic        o_rw, o_stall, o_stalled;
    logic [7:0]  o_data, o_dl;
`ifdef CPU6502_BUS_CYCLE_COUNT_EN
    logic [15:0] o_cycle_count;
`endif

    int total = 0;
    int bad   = 0;

    always #5 i_clk = ~i_clk;

    cpu6502_bus_interface dut (
        .i_clk     (i_clk),
        .i_reset   (i_reset),
        .i_adl_abl (i_adl_abl),
        .i_adh_abh (i_adh_abh),
        .i_adl     (i_adl),
        .i_adh     (i_adh),
        .i_db_dor  (i_db_dor),
        .i_db      (i_db),
        .i_rw      (i_rw),
        .i_rdy     (i_rdy),
        .i_data    (i_data),
        .o_address (o_address),
        .o_rw      (o_rw),
        .o_data    (o_data),
        .o_dl      (o_dl),
        .o_stall   (o_stall),
        .o_stalled (o_stalled)
`ifdef CPU6502_BUS_CYCLE_COUNT_EN
        ,
        .o_cycle_count (o_cycle_count)
`endif
    );

    task automatic check(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    initial begin
        i_reset = 1'b0; i_adl_abl = 1'b0; i_adh_abh = 1'b0; i_db_dor = 1'b0;
        i_rw = 1'b1; i_rdy = 1'b1;
        i_adl = 8'h00; i_adh = 8'h00; i_db = 8'h00; i_data = 8'h00;

        // Reset asserted mid-cycle, checked before the first clock edge.
        #3 i_reset = 1'b1;
        #1;
        check("rst_addr", o_address, 16'h0000);
        check("rst_rw", {15'd0, o_rw}, 16'd1);
        check("rst_data", {8'd0, o_data}, 16'h0000);
        check("rst_dl", {8'd0, o_dl}, 16'h0000);
        check("rst_stalled", {15'd0, o_stalled}, 16'd0);
        tick();
        i_reset = 1'b0;

        // Both halves loaded together; the read also captures i_data.
        i_adl = 8'h34; i_adh = 8'h12; i_adl_abl = 1'b1; i_adh_abh = 1'b1; i_data = 8'h11;
        tick();
        check("addr_both", o_address, 16'h1234);
        check("dl_read", {8'd0, o_dl}, 16'h0011);

        i_adl = 8'h56; i_adh = 8'h99; i_adh_abh = 1'b0;
        tick();
        check("addr_abl_only", o_address, 16'h1256);

        // Read stall: ABL load pulsed with FF must be ignored while held.
        i_rdy = 1'b0; i_adl = 8'hFF; i_data = 8'h77;
        #1;
        check("stall_comb", {15'd0, o_stall}, 16'd1);
        for (int i = 0; i < 3; i++) begin
            i_adl_abl = (i != 1);
            tick();
            check("stall_addr", o_address, 16'h1256);
            check("stall_flag", {15'd0, o_stall}, 16'd1);
            check("stalled_flag", {15'd0, o_stalled}, 16'd1);
            check("stall_dl", {8'd0, o_dl}, 16'h0011);
        end
        i_adl_abl = 1'b0; i_rdy = 1'b1; i_data = 8'hA5;
        #1;
        check("release_comb", {15'd0, o_stall}, 16'd0);
        tick();
        check("release_dl", {8'd0, o_dl}, 16'h00A5);
        check("release_stalled", {15'd0, o_stalled}, 16'd0);
        check("release_addr", o_address, 16'h1256);

        // Write; the completing cycle is still a read so DL takes 5A.
        i_db = 8'h3C; i_db_dor = 1'b1; i_rw = 1'b0; i_data = 8'h5A;
        tick();
        check("wr_rw", {15'd0, o_rw}, 16'd0);
        check("wr_data", {8'd0, o_data}, 16'h003C);
        check("wr_dl", {8'd0, o_dl}, 16'h005A);

        // RDY low during a write has no effect.
        i_db_dor = 1'b0; i_rdy = 1'b0; i_data = 8'hEE; i_db = 8'h99;
        #1;
        check("wr_nostall", {15'd0, o_stall}, 16'd0);
        tick();
        check("wr_stalled", {15'd0, o_stalled}, 16'd0);
        check("wr_dl_hold", {8'd0, o_dl}, 16'h005A);
        check("wr_dor_hold", {8'd0, o_data}, 16'h003C);

        // Write completes into a read while RDY stays low.
        i_rw = 1'b1;
        tick();
        check("rd_rw", {15'd0, o_rw}, 16'd1);
        check("rd_data_zero", {8'd0, o_data}, 16'h0000);
        check("rd_stall", {15'd0, o_stall}, 16'd1);
        tick();
        check("rd_stalled", {15'd0, o_stalled}, 16'd1);

        // Reset mid-stall.
        #2 i_reset = 1'b1;
        #1;
        check("rst2_stalled", {15'd0, o_stalled}, 16'd0);
        check("rst2_addr", o_address, 16'h0000);
        check("rst2_dl", {8'd0, o_dl}, 16'h0000);
        check("rst2_rw", {15'd0, o_rw}, 16'd1);
        tick();
        i_reset = 1'b0;

`ifdef CPU6502_BUS_CYCLE_COUNT_EN
        check("cnt_rst", o_cycle_count, 16'h0000);
        i_rdy = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        i_rdy = 1'b0;
        for (int i = 0; i < 2; i++) tick();
        check("cnt_5", o_cycle_count, 16'd5);
        i_rdy = 1'b1;
        for (int i = 0; i < 65530; i++) tick();
        check("cnt_ffff", o_cycle_count, 16'hFFFF);
        tick();
        check("cnt_wrap", o_cycle_count, 16'h0000);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cpu6502_bus_interface.md
# cpu6502_bus_interface

Drives the 6502 core's external memory bus from its internal buses. Internal ADL/ADH and DB buses are latched into the address bus low/high (ABL/ABH), data output (DOR) and read/write registers, and presented to memory. Read data is captured into the data latch (DL) for the core's internal buses. External RDY is honoured by stalling read cycles. The block sits between the internal bus routing (PCL/PCH, ALU, register file) and the system memory map.

## Interface
Parameters:
- none

Ports:
- i_clk  input  1  core clock; all registers update on its rising edge
- i_reset  input  1  asynchronous, active-high reset
- i_adl_abl  input  1  control: load ABL from i_adl
- i_adh_abh  input  1  control: load ABH from i_adh
- i_adl  input  8  internal ADL bus
- i_adh  input  8  internal ADH bus
- i_db_dor  input  1  control: load DOR from i_db
- i_db  input  8  internal data bus
- i_rw  input  1  control: RW for the next bus cycle (1 = read, 0 = write)
- i_rdy  input  1  external ready; low stretches read cycles
- i_data  input  8  external memory read data
- o_address  output  16  {ABH, ABL}
- o_rw  output  1  registered RW
- o_data  output  8  DOR when o_rw = 0, else 8'h00
- o_dl  output  8  data latch contents, for the internal buses
- o_stall  output  1  combinational: current cycle is being held (o_rw & ~i_rdy)
- o_stalled  output  1  registered: FSM is in STALLED
- o_cycle_count  output  16  completed bus cycles; present only with CPU6502_BUS_CYCLE_COUNT_EN

## Operation
- Reset values:
  - ABL = ABH = 8'h00, so o_address = 16'h0000.
  - DOR = 8'h00, DL = 8'h00.
  - o_rw = 1, so o_data = 8'h00.
  - FSM = ACTIVE, o_stalled = 0.
  - o_cycle_count = 0.
- A bus cycle is one i_clk period. It completes at the rising edge where o_stall = 0.
- On a completing edge:
  - ABL loads i_adl if i_adl_abl; ABH loads i_adh if i_adh_abh. Independent loads; unloaded half holds.
  - DOR loads i_db if i_db_dor.
  - o_rw loads i_rw.
  - If the completing cycle was a read (o_rw = 1), DL captures i_data. On a write, DL holds.
- On a held edge (o_stall = 1):
  - All control inputs are ignored.
  - ABL, ABH, DOR, o_rw and DL hold; the same read is re-presented.
- Writes never stall; i_rdy is don't-care while o_rw = 0.
- FSM states:
  - ACTIVE -> STALLED when o_rw = 1 and i_rdy = 0 at the edge.
  - STALLED -> ACTIVE when i_rdy = 1 at the edge; that edge completes the read and DL captures i_data.
  - STALLED -> STALLED while i_rdy = 0.
- o_stalled = 1 exactly in STALLED.
- Reset asserted mid-stall forces ACTIVE and all reset values immediately (asynchronously).
- Simultaneous load of ABL and ABH in one cycle is legal and typical (e.g. a JMP operand fetch).

## Timing
- Control inputs to o_address/o_rw/o_data: one cycle latency (registered).
- i_data to o_dl: valid the cycle after the completing edge.
- o_stall is combinational from i_rdy and o_rw; there is no register in that path.
- i_rdy has no effect while o_rw = 0, including when RDY drops during a write.

## Configuration
- CPU6502_BUS_CYCLE_COUNT_EN defined:
  - Adds the o_cycle_count port and a 16-bit counter.
  - The counter increments on every completing edge and wraps 16'hFFFF -> 16'h0000.
  - The counter holds on held edges.
  - Reset clears the counter.
- Macro undefined: the port and the counter are absent, and all other behaviour is identical.

## Structure
- Shared cpu6502 package holds:
  - RW encoding constants RW_READ = 1'b1 and RW_WRITE = 1'b0.
  - The bus FSM state typedef (ACTIVE, STALLED).
- One sub-module: cpu6502_address_bus_register.
  - 8-bit load-enable register with async reset.
  - Instantiated twice, for ABL and ABH.
- DOR, DL, RW and the FSM live in the top level.

## Test plan
- Reset: assert i_reset mid-cycle -> o_address = 16'h0000, o_rw = 1, o_data = 8'h00, o_dl = 8'h00, o_stalled = 0 with no clock edge.
- Address load: i_adl = 8'h34, i_adh = 8'h12, both loads asserted, then one edge -> o_address = 16'h1234. Next, load only ABL = 8'h56 -> o_address = 16'h1256.
- Read with stall:
  - Setup: o_rw = 1, i_rdy = 0 for 3 edges while i_adl_abl is pulsed with 8'hFF.
  - Required while held: o_address unchanged, o_stall = 1, o_stalled = 1.
  - Then i_rdy = 1, i_data = 8'hA5 -> o_dl = 8'hA5 and FSM returns to ACTIVE.
- Write: i_db = 8'h3C, i_db_dor = 1, i_rw = 0 -> next cycle o_rw = 0, o_data = 8'h3C. Dropping i_rdy then leaves o_stall = 0 and the cycle completes.
- Reset during stall: hold i_rdy = 0 on a read, then assert i_reset -> FSM ACTIVE, o_stalled = 0, o_address = 16'h0000.
- Counter (macro on):
  - 5 completing cycles plus 2 held cycles -> o_cycle_count = 5.
  - Preload by running to 16'hFFFF; one more completing cycle -> 16'h0000.
